// File: rtl/cpu_mult_pkg.sv
// Shared types and constants for the iterative multiplier.
// The optional early-exit path is selected with the CPU_MULT_EARLY_EXIT_EN macro.
package cpu_mult_pkg;

  // Control FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    SIGN = 2'd2
  } state_e;

  // Index of the partial product being accumulated (0..3).
  typedef logic [1:0] part_idx_t;

  // Acceptance-to-done latency in clocks.
  localparam int LATENCY_FULL  = 5;
  localparam int LATENCY_EARLY = 2;

endpackage

// File: rtl/cpu_mult_half.sv
// Combinational unsigned HALF_W x HALF_W -> 2*HALF_W multiplier.
// Kept as its own module so it maps onto a single DSP block.
module cpu_mult_half #(
  parameter int HALF_W = 16
) (
  input  logic [HALF_W-1:0]   a_i,
  input  logic [HALF_W-1:0]   b_i,
  output logic [2*HALF_W-1:0] prod_o
);

  // Both operands are zero-extended so the product is computed at full width.
  assign prod_o = {{HALF_W{1'b0}}, a_i} * {{HALF_W{1'b0}}, b_i};

endmodule

// File: rtl/cpu_mult_iter.sv
// Multi-cycle signed/unsigned multiplier producing the full 2*DATA_W product.
// One half-width multiplier is reused over four partial-product cycles, then
// a sign-fix cycle presents the result with a one-cycle done pulse.
// Optional: CPU_MULT_EARLY_EXIT_EN skips partials 1..3 when both operand
// magnitudes fit in the lower half.
//
// Handshake: an operation is accepted on a rising edge where start && ready
// && !flush. ready is high in IDLE and in the done cycle, so a new operation
// may be accepted on the edge that retires the previous one. done is high for
// exactly one cycle, and result_hi/result_lo are valid in that cycle and hold
// until the next done. flush abandons any operation on the next edge.
module cpu_mult_iter
  import cpu_mult_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              flush,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  input  logic              src1_signed,
  input  logic              src2_signed,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result_lo,
  output logic [DATA_W-1:0] result_hi,
  output state_e            dbg_state
);

  localparam int HALF_W = DATA_W / 2;
  localparam int PROD_W = 2 * DATA_W;

  state_e            state_q, state_d;
  part_idx_t         cnt_q, cnt_d;
  logic [PROD_W-1:0] acc_q, acc_d;
  logic [PROD_W-1:0] res_q, res_d;
  logic [DATA_W-1:0] mag_a_q, mag_a_d;
  logic [DATA_W-1:0] mag_b_q, mag_b_d;
  logic              neg_q, neg_d;

  logic [DATA_W-1:0] mag_a_in, mag_b_in;
  logic [HALF_W-1:0] half_a, half_b;
  logic [DATA_W-1:0] half_prod;
  logic [PROD_W-1:0] partial;
  logic [PROD_W-1:0] signed_acc;
  logic              accept, commit, last_part;

`ifdef CPU_MULT_EARLY_EXIT_EN
  logic early_q, early_d;
`endif

  // Operand magnitudes; the most-negative value maps to itself, which is
  // still the correct unsigned magnitude.
  assign mag_a_in = (src1_signed && src1[DATA_W-1]) ? -src1 : src1;
  assign mag_b_in = (src2_signed && src2[DATA_W-1]) ? -src2 : src2;

  assign ready  = (state_q == IDLE) || (state_q == SIGN);
  assign busy   = ~ready;
  assign accept = start && ready && !flush;
  assign commit = (state_q == SIGN) && !flush;

  // Partial index bit 0 selects the A half, bit 1 selects the B half.
  assign half_a = cnt_q[0] ? mag_a_q[DATA_W-1:HALF_W] : mag_a_q[HALF_W-1:0];
  assign half_b = cnt_q[1] ? mag_b_q[DATA_W-1:HALF_W] : mag_b_q[HALF_W-1:0];

  cpu_mult_half #(
    .HALF_W (HALF_W)
  ) u_half (
    .a_i    (half_a),
    .b_i    (half_b),
    .prod_o (half_prod)
  );

  // Align the partial by HALF_W per upper-half operand it uses.
  always_comb begin
    partial = {{DATA_W{1'b0}}, half_prod};
    case (cnt_q)
      2'd1, 2'd2: partial = {{DATA_W{1'b0}}, half_prod} << HALF_W;
      2'd3:       partial = {{DATA_W{1'b0}}, half_prod} << DATA_W;
      default:    ;
    endcase
  end

`ifdef CPU_MULT_EARLY_EXIT_EN
  assign last_part = (cnt_q == 2'd3) || early_q;
`else
  assign last_part = (cnt_q == 2'd3);
`endif

  assign signed_acc = neg_q ? -acc_q : acc_q;

  // The result is visible combinationally in the done cycle, otherwise the held copy.
  assign {result_hi, result_lo} = commit ? signed_acc : res_q;
  assign done      = commit;
  assign dbg_state = state_q;

  // Next-state logic: accumulate in MUL, retire in SIGN, accept when ready.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    res_d   = res_q;
    mag_a_d = mag_a_q;
    mag_b_d = mag_b_q;
    neg_d   = neg_q;
`ifdef CPU_MULT_EARLY_EXIT_EN
    early_d = early_q;
`endif
    if (flush) begin
      state_d = IDLE;
    end else begin
      if (state_q == MUL) begin
        acc_d = acc_q + partial;
        if (last_part) state_d = SIGN;
        else           cnt_d   = cnt_q + 2'd1;
      end
      if (commit) begin
        res_d   = signed_acc;
        state_d = IDLE;
      end
      if (accept) begin
        mag_a_d = mag_a_in;
        mag_b_d = mag_b_in;
        neg_d   = (src1_signed && src1[DATA_W-1]) ^ (src2_signed && src2[DATA_W-1]);
        acc_d   = '0;
        cnt_d   = '0;
        state_d = MUL;
`ifdef CPU_MULT_EARLY_EXIT_EN
        early_d = (mag_a_in[DATA_W-1:HALF_W] == '0) && (mag_b_in[DATA_W-1:HALF_W] == '0);
`endif
      end
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      mag_a_q <= '0;
      mag_b_q <= '0;
      neg_q   <= 1'b0;
`ifdef CPU_MULT_EARLY_EXIT_EN
      early_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      mag_a_q <= mag_a_d;
      mag_b_q <= mag_b_d;
      neg_q   <= neg_d;
`ifdef CPU_MULT_EARLY_EXIT_EN
      early_q <= early_d;
`endif
    end
  end

endmodule

// File: tb/tb_cpu_mult_iter.sv
// Self-checking bench for cpu_mult_iter: directed corner cases plus random
// operations compared against an arithmetic reference product.
module tb_cpu_mult_iter;
  import cpu_mult_pkg::*;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic          flush;
  logic [DW-1:0] src1, src2;
  logic          src1_signed, src2_signed;
  logic          ready, busy, done;
  logic [DW-1:0] result_lo, result_hi;
  state_e        dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  logic [2*DW-1:0] last_res;
  logic [2*DW-1:0] exp_q[$];

  cpu_mult_iter #(.DATA_W(DW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .flush       (flush),
    .src1        (src1),
    .src2        (src2),
    .src1_signed (src1_signed),
    .src2_signed (src2_signed),
    .ready       (ready),
    .busy        (busy),
    .done        (done),
    .result_lo   (result_lo),
    .result_hi   (result_hi),
    .dbg_state   (dbg_state)
  );

  // Clock generation.
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [2*DW-1:0] got, input logic [2*DW-1:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Reference: sign/zero extend both operands to 2*DW and multiply.
  function automatic logic [2*DW-1:0] ref_mul(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                              input logic sa, input logic sb);
    logic signed [2*DW-1:0] ea, eb;
    ea = sa ? {{DW{a[DW-1]}}, a} : {{DW{1'b0}}, a};
    eb = sb ? {{DW{b[DW-1]}}, b} : {{DW{1'b0}}, b};
    return ea * eb;
  endfunction

  // Expected acceptance-to-done latency for an operand pair.
  function automatic int exp_lat(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                 input logic sa, input logic sb);
    logic [DW-1:0] ma, mb;
    ma = (sa && a[DW-1]) ? -a : a;
    mb = (sb && b[DW-1]) ? -b : b;
`ifdef CPU_MULT_EARLY_EXIT_EN
    return (ma < (1 << (DW/2)) && mb < (1 << (DW/2))) ? LATENCY_EARLY : LATENCY_FULL;
`else
    return (ma == mb || ma != mb) ? LATENCY_FULL : LATENCY_FULL;
`endif
  endfunction

  // Scoreboard: every done pops one expected product.
  always @(negedge clk) begin
    if (reset_n && done) begin
      done_cnt++;
      if (exp_q.size() == 0) check("unexpected_done", 1, 0);
      else check("result", {result_hi, result_lo}, exp_q.pop_front());
    end
  end

  // Issue one operation and watch its timing and the busy-period outputs.
  task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic sa, input logic sb, input logic [2*DW-1:0] exp);
    int  lat;
    bit  seen;
    lat = exp_lat(a, b, sa, sb);
    @(negedge clk);
    start = 1'b1; src1 = a; src2 = b; src1_signed = sa; src2_signed = sb;
    exp_q.push_back(exp);
    @(posedge clk);
    seen = 1'b0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(negedge clk);
      start = 1'b0;
      src1 = $urandom; src2 = $urandom;
      if (done) begin
        seen = 1'b1;
        check("latency", 64'(k), 64'(lat));
        check("ready_in_done", 64'(ready), 1);
        last_res = exp;
      end else begin
        check("busy_ready", 64'({busy, ready}), 2'b10);
        check("result_hold", {result_hi, result_lo}, last_res);
      end
    end
    if (!seen) check("done_timeout", 0, 1);
  endtask

  initial begin
    logic [DW-1:0] a, b;
    logic sa, sb;
    int first, second, d0;

    reset_n = 1'b0; start = 1'b0; flush = 1'b0;
    src1 = '0; src2 = '0; src1_signed = 1'b0; src2_signed = 1'b0;
    last_res = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 64'(ready), 1);
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);
    check("rst_result", {result_hi, result_lo}, 0);
    check("rst_state", 64'(dbg_state), 64'(IDLE));

    // Directed corner cases.
    run_op(32'd3, 32'd5, 1'b0, 1'b0, 64'h0000_0000_0000_000F);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 64'hFFFF_FFFE_0000_0001);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 64'h0000_0000_0000_0001);
    run_op(32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFA);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 64'h4000_0000_0000_0000);
    run_op(32'hFFFF_FFFF, 32'd5, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFB);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 64'hFFFF_FFFF_8000_0000);
    run_op(32'h0000_1234, 32'h0000_0010, 1'b0, 1'b0, 64'h0000_0000_0001_2340);
    run_op(32'h0001_0000, 32'h0000_0002, 1'b0, 1'b0, 64'h0000_0000_0002_0000);

    // Back-to-back with start held high; busy-period operands must be ignored.
    @(negedge clk);
    start = 1'b1; src1 = 32'd7; src2 = 32'd6; src1_signed = 1'b0; src2_signed = 1'b0;
    exp_q.push_back(64'd42);
    first = 0; second = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (done) begin
        if (first == 0) begin
          first = k; src1 = 32'd9; src2 = 32'd9;
          exp_q.push_back(64'd81);
        end else if (second == 0) begin
          second = k;
        end
      end else if (first == 0) begin
        src1 = $urandom; src2 = $urandom;
      end
      if (first != 0 && k == first + 1) start = 1'b0;
    end
    check("b2b_first", 64'(first), 64'(exp_lat(32'd7, 32'd6, 1'b0, 1'b0)));
    check("b2b_second", 64'(second), 64'(first + exp_lat(32'd9, 32'd9, 1'b0, 1'b0)));
    last_res = 64'd81;

    // Flush in the middle of an operation.
    @(negedge clk);
    start = 1'b1; src1 = 32'h1234_5678; src2 = 32'h9ABC_DEF0;
    d0 = done_cnt;
    @(posedge clk);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 3) flush = 1'b1;
    end
    @(negedge clk);
    flush = 1'b0;
    check("flush_ready", 64'(ready), 1);
    check("flush_result", {result_hi, result_lo}, last_res);
    repeat (8) @(negedge clk);
    check("flush_no_done", 64'(done_cnt), 64'(d0));

    // Flush and start together in IDLE: nothing is accepted.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; src1 = 32'd100; src2 = 32'd3;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_start_ready", 64'(ready), 1);
    check("flush_start_state", 64'(dbg_state), 64'(IDLE));
    repeat (8) @(negedge clk);
    check("flush_start_no_done", 64'(done_cnt), 64'(d0));

    // Reset in the middle of an operation.
    @(negedge clk);
    start = 1'b1; src1 = 32'hDEAD_BEEF; src2 = 32'h7777_0001;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("arst_result", {result_hi, result_lo}, 0);
    check("arst_ready", 64'(ready), 1);
    check("arst_busy", 64'(busy), 0);
    check("arst_done", 64'(done), 0);
    last_res = '0;
    @(negedge clk);
    reset_n = 1'b1;
    run_op(32'd4, 32'd4, 1'b0, 1'b0, 64'd16);

    // Random operations with a bias toward small operands.
    for (int i = 0; i < 40; i++) begin
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 3) == 0) a = DW'($urandom_range(0, 16'hFFFF));
      if ($urandom_range(0, 3) == 0) b = DW'($urandom_range(0, 16'hFFFF));
      sa = 1'($urandom_range(0, 1));
      sb = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_op(a, b, sa, sb, ref_mul(a, b, sa, sb));
    end

    repeat (3) @(negedge clk);
    check("exp_q_drained", 64'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
